// File: rtl/reg_scoreboard.sv
// Per-register pending-write scoreboard for the in-order 5-stage LoongArch pipeline.
// Each GPR r1..r(NREG-1) owns a small counter of in-flight writers (EX/MEM/WB).
// ID is stalled while any register it reads still has a pending writer.
// r0 is hardwired to zero, so it has no counter and never stalls.
module reg_scoreboard #(
   parameter int CNT_W = 2,
   parameter int NREG  = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            ds_valid,
   input  logic            rs1_used,
   input  logic [4:0]      rs1_addr,
   input  logic            rs2_used,
   input  logic [4:0]      rs2_addr,
   input  logic            issue,
   input  logic            issue_gr_we,
   input  logic [4:0]      issue_dest,
   input  logic            retire,
   input  logic [4:0]      retire_dest,
   input  logic            clear,
   output logic            ds_stall,
   output logic [NREG-1:0] busy_vec,
   output logic            sb_err
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   // Per-register overflow / underflow events, bit 0 unused (r0 is never tracked)
   logic [NREG-1:0] ovf_vec;
   logic [NREG-1:0] udf_vec;

   // Qualified increment / decrement requests
   logic inc_req;
   logic dec_req;
   logic proto_err;

   assign inc_req   = issue & issue_gr_we & (issue_dest != 5'd0);
   assign dec_req   = retire & (retire_dest != 5'd0);

   assign ovf_vec[0]  = 1'b0;
   assign udf_vec[0]  = 1'b0;
   assign busy_vec[0] = 1'b0;

   genvar i;
   generate
      for (i = 1; i < NREG; i++) begin : g_reg
         localparam logic [4:0] IDX = 5'(i);

         logic [CNT_W-1:0] cnt;
         logic             inc_hit;
         logic             dec_hit;

         assign inc_hit = inc_req & (issue_dest == IDX);
         assign dec_hit = dec_req & (retire_dest == IDX);

         // Pending-writer counter: issue adds, retire subtracts, both at once cancel,
         // and the count saturates at either end instead of wrapping.
         always_ff @(posedge clk) begin
            if (reset || clear) begin
               cnt <= '0;
            end else if (inc_hit && !dec_hit) begin
               if (cnt != CNT_MAX) begin
                  cnt <= cnt + CNT_ONE;
               end
            end else if (dec_hit && !inc_hit) begin
               if (cnt != '0) begin
                  cnt <= cnt - CNT_ONE;
               end
            end
         end

         assign busy_vec[i] = |cnt;
         assign ovf_vec[i]  = ~clear & inc_hit & ~dec_hit & (cnt == CNT_MAX);
         assign udf_vec[i]  = ~clear & dec_hit & ~inc_hit & (cnt == '0);
      end
   endgenerate

   // RAW stall from the registered counters only; busy_vec[0] is zero so r0 never stalls.
   // A same-cycle retire does not release the stall because the regfile has no bypass.
   always_comb begin
      ds_stall = 1'b0;
      if (ds_valid) begin
         ds_stall = (rs1_used & busy_vec[rs1_addr]) | (rs2_used & busy_vec[rs2_addr]);
      end
   end

   assign proto_err = issue & ds_stall;

   // Sticky error flag: only reset clears it, a pipeline flush leaves it set.
   always_ff @(posedge clk) begin
      if (reset) begin
         sb_err <= 1'b0;
      end else if (proto_err || (|ovf_vec) || (|udf_vec)) begin
         sb_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed self-checking bench for reg_scoreboard with hand-computed expectations.
module tb_reg_scoreboard;

   logic        clk;
   logic        reset;
   logic        ds_valid;
   logic        rs1_used;
   logic [4:0]  rs1_addr;
   logic        rs2_used;
   logic [4:0]  rs2_addr;
   logic        issue;
   logic        issue_gr_we;
   logic [4:0]  issue_dest;
   logic        retire;
   logic [4:0]  retire_dest;
   logic        clear;
   logic        ds_stall;
   logic [31:0] busy_vec;
   logic        sb_err;

   int vectors;
   int miscompares;

   reg_scoreboard #(.CNT_W(2), .NREG(32)) dut (
      .clk         (clk),
      .reset       (reset),
      .ds_valid    (ds_valid),
      .rs1_used    (rs1_used),
      .rs1_addr    (rs1_addr),
      .rs2_used    (rs2_used),
      .rs2_addr    (rs2_addr),
      .issue       (issue),
      .issue_gr_we (issue_gr_we),
      .issue_dest  (issue_dest),
      .retire      (retire),
      .retire_dest (retire_dest),
      .clear       (clear),
      .ds_stall    (ds_stall),
      .busy_vec    (busy_vec),
      .sb_err      (sb_err)
   );

   // Free-running 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Compare one observed value against its expected value and tally the result
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance one clock; inputs are changed 1 ns after the edge, outputs settle by then
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one cycle of issue/retire/clear, then drop those strobes again
   task automatic applyStimulus(input logic iss, input logic we, input logic [4:0] dest,
                                input logic ret, input logic [4:0] rdest, input logic clr);
      issue       = iss;
      issue_gr_we = we;
      issue_dest  = dest;
      retire      = ret;
      retire_dest = rdest;
      clear       = clr;
      tick();
      issue       = 1'b0;
      issue_gr_we = 1'b0;
      issue_dest  = 5'd0;
      retire      = 1'b0;
      retire_dest = 5'd0;
      clear       = 1'b0;
      #1;
   endtask

   task automatic setRead(input logic v, input logic u1, input logic [4:0] a1,
                          input logic u2, input logic [4:0] a2);
      ds_valid = v;
      rs1_used = u1;
      rs1_addr = a1;
      rs2_used = u2;
      rs2_addr = a2;
      #1;
   endtask

   // Hold reset for two cycles with every input idle
   task automatic doReset();
      setRead(1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      #1;
   endtask

   // Directed scenarios
   initial begin
      vectors     = 0;
      miscompares = 0;
      reset = 1'b1;
      clear = 1'b0;
      issue = 1'b0; issue_gr_we = 1'b0; issue_dest = 5'd0;
      retire = 1'b0; retire_dest = 5'd0;
      setRead(1'b0, 1'b0, 5'd0, 1'b0, 5'd0);

      // Reset held with random traffic: nothing may be recorded
      for (int k = 0; k < 4; k++) begin
         issue       = 1'b1;
         issue_gr_we = 1'b1;
         issue_dest  = 5'($urandom_range(1, 31));
         retire      = 1'($urandom);
         retire_dest = 5'($urandom);
         ds_valid    = 1'b1;
         rs1_used    = 1'b1;
         rs1_addr    = issue_dest;
         tick();
      end
      checkOutput("busy_in_reset", busy_vec, 32'h0);
      issue = 1'b0; issue_gr_we = 1'b0; issue_dest = 5'd0;
      retire = 1'b0; retire_dest = 5'd0;
      setRead(1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
      reset = 1'b0;
      tick();
      checkOutput("rst_busy", busy_vec, 32'h0);
      checkOutput("rst_stall", {31'd0, ds_stall}, 32'd0);
      checkOutput("rst_err", {31'd0, sb_err}, 32'd0);

      // Self-dependence: add.w r4,r4,r5 issuing while r4 is idle does not stall
      setRead(1'b1, 1'b1, 5'd4, 1'b1, 5'd5);
      checkOutput("self_dep_stall", {31'd0, ds_stall}, 32'd0);
      applyStimulus(1'b1, 1'b1, 5'd4, 1'b0, 5'd0, 1'b0);
      checkOutput("r4_busy", busy_vec, 32'h0000_0010);
      checkOutput("r4_stall_c1", {31'd0, ds_stall}, 32'd1);
      tick();
      checkOutput("r4_stall_c2", {31'd0, ds_stall}, 32'd1);
      retire = 1'b1; retire_dest = 5'd4; #1;
      checkOutput("r4_stall_retire_cycle", {31'd0, ds_stall}, 32'd1);
      tick();
      retire = 1'b0; retire_dest = 5'd0; #1;
      checkOutput("r4_stall_released", {31'd0, ds_stall}, 32'd0);
      checkOutput("r4_busy_cleared", busy_vec, 32'h0);
      checkOutput("r4_err", {31'd0, sb_err}, 32'd0);
      setRead(1'b0, 1'b0, 5'd0, 1'b0, 5'd0);

      // Saturation on r7
      for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b1, 5'd7, 1'b0, 5'd0, 1'b0);
      checkOutput("r7_busy_full", busy_vec, 32'h0000_0080);
      checkOutput("r7_err_full", {31'd0, sb_err}, 32'd0);
      applyStimulus(1'b1, 1'b1, 5'd7, 1'b0, 5'd0, 1'b0);
      checkOutput("r7_err_ovf", {31'd0, sb_err}, 32'd1);
      applyStimulus(1'b0, 1'b0, 5'd0, 1'b1, 5'd7, 1'b0);
      applyStimulus(1'b0, 1'b0, 5'd0, 1'b1, 5'd7, 1'b0);
      checkOutput("r7_busy_after2", busy_vec, 32'h0000_0080);
      applyStimulus(1'b0, 1'b0, 5'd0, 1'b1, 5'd7, 1'b0);
      checkOutput("r7_busy_after3", busy_vec, 32'h0);

      // Simultaneous issue and retire
      doReset();
      checkOutput("rst2_err", {31'd0, sb_err}, 32'd0);
      applyStimulus(1'b1, 1'b1, 5'd9, 1'b0, 5'd0, 1'b0);
      applyStimulus(1'b1, 1'b1, 5'd10, 1'b0, 5'd0, 1'b0);
      checkOutput("r9_r10_busy", busy_vec, 32'h0000_0600);
      applyStimulus(1'b1, 1'b1, 5'd9, 1'b1, 5'd9, 1'b0);
      checkOutput("same_reg_net0", busy_vec, 32'h0000_0600);
      applyStimulus(1'b1, 1'b1, 5'd9, 1'b1, 5'd10, 1'b0);
      checkOutput("diff_reg", busy_vec, 32'h0000_0200);
      applyStimulus(1'b0, 1'b0, 5'd0, 1'b1, 5'd9, 1'b0);
      checkOutput("r9_cnt2_to_1", busy_vec, 32'h0000_0200);
      applyStimulus(1'b0, 1'b0, 5'd0, 1'b1, 5'd9, 1'b0);
      checkOutput("r9_cnt1_to_0", busy_vec, 32'h0);
      checkOutput("simul_err", {31'd0, sb_err}, 32'd0);

      // r0 and non-writing issues are ignored
      applyStimulus(1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
      applyStimulus(1'b1, 1'b0, 5'd5, 1'b0, 5'd0, 1'b0);
      checkOutput("r0_nowe_busy", busy_vec, 32'h0);
      setRead(1'b1, 1'b1, 5'd0, 1'b1, 5'd0);
      checkOutput("r0_stall", {31'd0, ds_stall}, 32'd0);
      setRead(1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
      applyStimulus(1'b0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b0);
      checkOutput("r0_retire_err", {31'd0, sb_err}, 32'd0);

      // Second read port and qualifiers
      applyStimulus(1'b1, 1'b1, 5'd12, 1'b0, 5'd0, 1'b0);
      setRead(1'b1, 1'b1, 5'd3, 1'b1, 5'd12);
      checkOutput("rs2_stall", {31'd0, ds_stall}, 32'd1);
      setRead(1'b1, 1'b1, 5'd12, 1'b0, 5'd12);
      checkOutput("rs1_stall", {31'd0, ds_stall}, 32'd1);
      setRead(1'b1, 1'b0, 5'd12, 1'b0, 5'd12);
      checkOutput("unused_no_stall", {31'd0, ds_stall}, 32'd0);
      setRead(1'b0, 1'b1, 5'd12, 1'b1, 5'd12);
      checkOutput("invalid_no_stall", {31'd0, ds_stall}, 32'd0);
      setRead(1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
      applyStimulus(1'b0, 1'b0, 5'd0, 1'b1, 5'd12, 1'b0);
      checkOutput("r12_cleared", busy_vec, 32'h0);

      // Issue under stall flags an error but still records the write, clear keeps the flag
      applyStimulus(1'b1, 1'b1, 5'd3, 1'b0, 5'd0, 1'b0);
      applyStimulus(1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0);
      setRead(1'b1, 1'b1, 5'd3, 1'b0, 5'd0);
      checkOutput("r3_stall", {31'd0, ds_stall}, 32'd1);
      applyStimulus(1'b1, 1'b1, 5'd6, 1'b0, 5'd0, 1'b0);
      checkOutput("proto_err", {31'd0, sb_err}, 32'd1);
      checkOutput("proto_busy", busy_vec, 32'h0000_0068);
      setRead(1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
      applyStimulus(1'b1, 1'b1, 5'd8, 1'b0, 5'd0, 1'b1);
      checkOutput("clear_busy", busy_vec, 32'h0);
      checkOutput("clear_keeps_err", {31'd0, sb_err}, 32'd1);

      // Clear then underflow
      doReset();
      applyStimulus(1'b1, 1'b1, 5'd3, 1'b0, 5'd0, 1'b0);
      applyStimulus(1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0);
      checkOutput("r3_r5_busy", busy_vec, 32'h0000_0028);
      applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1);
      setRead(1'b1, 1'b1, 5'd3, 1'b1, 5'd5);
      checkOutput("clear2_busy", busy_vec, 32'h0);
      checkOutput("clear2_stall", {31'd0, ds_stall}, 32'd0);
      checkOutput("clear2_err", {31'd0, sb_err}, 32'd0);
      setRead(1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
      applyStimulus(1'b0, 1'b0, 5'd0, 1'b1, 5'd3, 1'b0);
      checkOutput("udf_err", {31'd0, sb_err}, 32'd1);
      checkOutput("udf_busy", busy_vec, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
